// File: rtl/timer_device_if.sv
// Bridge-side bus bundle for one timer_device: word address, write strobe,
// write/read data and the interrupt line.
interface timer_device_if;
  logic [31:2] Addr;
  logic        WE;
  logic [31:0] Din;
  logic [31:0] Dout;
  logic        IRQ;

  modport master (output Addr, WE, Din, input Dout, IRQ);
  modport slave  (input Addr, WE, Din, output Dout, IRQ);
endinterface

// File: rtl/timer_device.sv
// 32-bit down-counting timer with one-shot / auto-reload modes and a maskable
// interrupt; CTRL, PRESET and COUNT are decoded on Addr[3:2].
module timer_device (
  input logic           clk,
  input logic           reset,
  timer_device_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, CNT, INT} state_e;

  state_e      state_q, state_d;
  logic [3:0]  ctrl_q, ctrl_d;
  logic [31:0] preset_q, preset_d;
  logic [31:0] count_q, count_d;
  logic        irq_flag_q, irq_flag_d;

  logic        wr_ctrl, wr_preset;
  logic        enable, auto_reload, im;
  logic        unused_addr;

  assign unused_addr = ^bus.Addr[31:4];
  assign wr_ctrl     = bus.WE && (bus.Addr[3:2] == 2'b00);
  assign wr_preset   = bus.WE && (bus.Addr[3:2] == 2'b01);
  assign enable      = ctrl_q[0];
  assign auto_reload = (ctrl_q[2:1] == 2'b01);
  assign im          = ctrl_q[3];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      ctrl_q     <= 4'd0;
      preset_q   <= 32'd0;
      count_q    <= 32'd0;
      irq_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      ctrl_q     <= ctrl_d;
      preset_q   <= preset_d;
      count_q    <= count_d;
      irq_flag_q <= irq_flag_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ctrl_d     = ctrl_q;
    preset_d   = preset_q;
    count_d    = count_q;
    irq_flag_d = irq_flag_q;

    case (state_q)
      IDLE: begin
        if (enable) state_d = LOAD;
      end
      LOAD: begin
        count_d = preset_q;
        state_d = CNT;
      end
      CNT: begin
        if (!enable) begin
          state_d = IDLE;
        end else if (count_q > 32'd1) begin
          count_d = count_q - 32'd1;
        end else begin
          count_d    = 32'd0;
          irq_flag_d = 1'b1;
          state_d    = INT;
        end
      end
      INT: begin
        if (auto_reload) irq_flag_d = 1'b0;
        else             ctrl_d[0]  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // CPU writes land last so they override any FSM update in the same cycle
    if (wr_ctrl) begin
      ctrl_d     = bus.Din[3:0];
      irq_flag_d = 1'b0;
    end
    if (wr_preset) begin
      preset_d   = bus.Din;
      irq_flag_d = 1'b0;
    end
  end

  always_comb begin
    bus.Dout = 32'd0;
    case (bus.Addr[3:2])
      2'b00:   bus.Dout = {28'd0, ctrl_q};
      2'b01:   bus.Dout = preset_q;
      2'b10:   bus.Dout = count_q;
      default: bus.Dout = 32'd0;
    endcase
  end

  assign bus.IRQ = im & irq_flag_q;

endmodule

// File: tb/tb_timer_device.sv
// Directed bench for timer_device: register map, one-shot, auto-reload,
// masked interrupt, mid-count stop, reset and edge presets.
module tb_timer_device;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_err;

  timer_device_if bus ();

  timer_device dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [1:0] off, input logic [31:0] data);
    bus.Addr = {28'd0, off};
    bus.Din  = data;
    bus.WE   = 1'b1;
    step();
    bus.WE   = 1'b0;
  endtask

  task automatic rd(input logic [1:0] off, input logic [31:0] exp, input string tag);
    bus.Addr = {28'd0, off};
    #1;
    check(tag, bus.Dout, exp);
  endtask

  initial begin
    logic [31:0] exp_cnt [0:8];
    logic        exp_irq;
    int          pulses;

    n_cmp    = 0;
    n_err    = 0;
    reset    = 1'b1;
    bus.Addr = '0;
    bus.WE   = 1'b0;
    bus.Din  = '0;
    step();
    step();
    reset = 1'b0;

    // Reset state
    rd(2'd0, 32'd0, "rst_ctrl");
    rd(2'd1, 32'd0, "rst_preset");
    rd(2'd2, 32'd0, "rst_count");
    rd(2'd3, 32'd0, "rst_rsvd");
    check("rst_irq", {31'd0, bus.IRQ}, 32'd0);

    // One-shot, PRESET=5, IM=1
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    bus.Addr = 30'd2;
    step();
    step();
    for (int k = 0; k < 5; k++) begin
      rd(2'd2, 32'd5 - k, $sformatf("os_count_%0d", k));
      check($sformatf("os_irq_lo_%0d", k), {31'd0, bus.IRQ}, 32'd0);
      step();
    end
    rd(2'd2, 32'd0, "os_count_zero");
    check("os_irq_rise", {31'd0, bus.IRQ}, 32'd1);
    step();
    rd(2'd0, 32'h8, "os_ctrl_after");
    check("os_irq_hold1", {31'd0, bus.IRQ}, 32'd1);
    step();
    check("os_irq_hold2", {31'd0, bus.IRQ}, 32'd1);
    wr(2'd0, 32'h0);
    check("os_irq_clr", {31'd0, bus.IRQ}, 32'd0);

    // Auto-reload, PRESET=3, IM=1: IRQ after edges 5, 11, 17
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    pulses = 0;
    for (int cyc = 1; cyc <= 20; cyc++) begin
      step();
      exp_irq = (cyc == 5) || (cyc == 11) || (cyc == 17);
      check($sformatf("ar_irq_c%0d", cyc), {31'd0, bus.IRQ}, {31'd0, exp_irq});
      if (bus.IRQ) pulses++;
    end
    check("ar_pulses", pulses, 32'd3);
    rd(2'd0, 32'hB, "ar_ctrl_kept");
    wr(2'd0, 32'h0);

    // Auto-reload with IM=0: COUNT still cycles, IRQ stays low
    wr(2'd1, 32'd3);
    wr(2'd0, 32'h3);
    exp_cnt = '{32'd0, 32'd0, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd3};
    for (int cyc = 1; cyc <= 8; cyc++) begin
      step();
      check($sformatf("nm_irq_c%0d", cyc), {31'd0, bus.IRQ}, 32'd0);
      if (cyc >= 2) rd(2'd2, exp_cnt[cyc], $sformatf("nm_count_c%0d", cyc));
    end
    wr(2'd0, 32'h0);

    // Mid-count stop: CTRL=0x8 written while COUNT reads 3 freezes it at 2
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h1);
    step();
    step();
    rd(2'd2, 32'd5, "mid_count_start");
    step();
    step();
    rd(2'd2, 32'd3, "mid_count_3");
    wr(2'd0, 32'h8);
    rd(2'd2, 32'd2, "mid_count_2");
    step();
    rd(2'd2, 32'd2, "mid_hold_a");
    step();
    step();
    rd(2'd2, 32'd2, "mid_hold_b");
    rd(2'd0, 32'h8, "mid_ctrl");
    wr(2'd2, 32'hFFFF);
    rd(2'd2, 32'd2, "count_wr_ignored");

    // Reset at COUNT=4 overrides a simultaneous PRESET write
    wr(2'd1, 32'd7);
    wr(2'd0, 32'h9);
    step();
    step();
    step();
    step();
    step();
    rd(2'd2, 32'd4, "rs_count_4");
    bus.Addr = 30'd1;
    bus.Din  = 32'h1234_5678;
    bus.WE   = 1'b1;
    reset    = 1'b1;
    step();
    bus.WE   = 1'b0;
    reset    = 1'b0;
    rd(2'd0, 32'd0, "rs_ctrl");
    rd(2'd1, 32'd0, "rs_preset");
    rd(2'd2, 32'd0, "rs_count");
    check("rs_irq", {31'd0, bus.IRQ}, 32'd0);

    // PRESET=0: IRQ 3 edges after enable
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    step();
    check("p0_irq_e1", {31'd0, bus.IRQ}, 32'd0);
    step();
    check("p0_irq_e2", {31'd0, bus.IRQ}, 32'd0);
    step();
    check("p0_irq_e3", {31'd0, bus.IRQ}, 32'd1);
    // CTRL write on the INT->IDLE edge: written value wins, flag cleared
    wr(2'd0, 32'h9);
    rd(2'd0, 32'h9, "int_wr_ctrl");
    check("int_wr_irq", {31'd0, bus.IRQ}, 32'd0);
    wr(2'd0, 32'h0);
    step();
    step();
    step();

    // PRESET=1: IRQ 3 edges after enable
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    step();
    check("p1_irq_e1", {31'd0, bus.IRQ}, 32'd0);
    step();
    check("p1_irq_e2", {31'd0, bus.IRQ}, 32'd0);
    step();
    check("p1_irq_e3", {31'd0, bus.IRQ}, 32'd1);
    rd(2'd2, 32'd0, "p1_count");

    // Only CTRL[3:0] is stored
    wr(2'd0, 32'hFFFF_FFFF);
    rd(2'd0, 32'hF, "ctrl_width");
    wr(2'd0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
